// File: rtl/bayer_to_gray_pkg.sv
// Shared pixel-stream definitions for the Bayer front end and the Sobel stage.
// Holds the default geometry, the pixel type and a counter-width helper.
package bayer_to_gray_pkg;

    localparam int PIXEL_WIDTH        = 12;
    localparam int DEFAULT_ROW_LENGTH = 1280;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int col_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bayer_to_gray_shift_register.sv
// Enable-gated delay line: o_data is the word accepted DEPTH shifts ago.
// Contents are not reset; consumers mask stale data themselves.
module shift_register #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1280
) (
    input  logic             i_clk,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_shift) begin
            mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign o_data = mem[DEPTH-1];

endmodule

// File: rtl/bayer_to_gray.sv
// Raw Bayer to grayscale: each output is the floor mean of the 2x2 window
// ending at the current pixel, with top/left edges replicated.
module bayer_to_gray
    import bayer_to_gray_pkg::*;
#(
    parameter int ROW_LENGTH = DEFAULT_ROW_LENGTH,
    parameter int PIXEL_W    = PIXEL_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PIXEL_W-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_sof,
    output logic [PIXEL_W-1:0] o_data,
    output logic               o_valid,
    output logic               o_sof
);

    // Handshake: valid-only stream, no ready. A pixel is accepted on every
    // cycle with i_valid=1; o_valid follows one cycle later and the consumer
    // must take every o_valid cycle. i_sof/o_sof only mean something with valid.

    localparam int                COL_W    = col_bits(ROW_LENGTH);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ROW_LENGTH - 1);
    localparam int                SUM_W    = PIXEL_W + 2;

    logic [COL_W-1:0]   col_cnt;
    logic               first_row;
    logic [PIXEL_W-1:0] cur_prev;
    logic [PIXEL_W-1:0] top_prev;
    logic [PIXEL_W-1:0] line_out;

    logic               sof_acc;
    logic [COL_W-1:0]   eff_col;
    logic               eff_first;
    logic               wrap;
    logic [COL_W-1:0]   col_nxt;
    logic               first_nxt;
    logic [PIXEL_W-1:0] pix_l;
    logic [PIXEL_W-1:0] pix_t;
    logic [PIXEL_W-1:0] pix_tl;
    logic [SUM_W-1:0]   sum;

    shift_register #(
        .WIDTH (PIXEL_W),
        .DEPTH (ROW_LENGTH)
    ) u_line_buf (
        .i_clk   (i_clk),
        .i_shift (i_valid),
        .i_data  (i_data),
        .o_data  (line_out)
    );

    always_comb begin
        sof_acc   = i_valid & i_sof;
        eff_col   = sof_acc ? '0 : col_cnt;
        eff_first = sof_acc | first_row;
        pix_l     = cur_prev;
        pix_t     = line_out;
        pix_tl    = top_prev;

        // Left edge first, then top edge, so the corner collapses to p.
        if (eff_col == '0) begin
            pix_l  = i_data;
            pix_tl = line_out;
        end
        if (eff_first) begin
            pix_t  = i_data;
            pix_tl = pix_l;
        end

        sum = SUM_W'(i_data) + SUM_W'(pix_l) + SUM_W'(pix_t) + SUM_W'(pix_tl);

        wrap      = (eff_col == LAST_COL);
        col_nxt   = wrap ? '0 : eff_col + COL_W'(1);
        first_nxt = eff_first & ~wrap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_sof     <= 1'b0;
            col_cnt   <= '0;
            first_row <= 1'b1;
            cur_prev  <= '0;
            top_prev  <= '0;
        end else begin
            o_valid <= i_valid;
            o_sof   <= sof_acc;
            if (i_valid) begin
                o_data    <= sum[SUM_W-1:2];
                col_cnt   <= col_nxt;
                first_row <= first_nxt;
                cur_prev  <= i_data;
                top_prev  <= line_out;
            end
        end
    end

endmodule

// File: tb/tb_bayer_to_gray.sv
// Bench for bayer_to_gray with a 4-pixel row: directed vectors plus random
// frames checked against a coordinate-based image model.
module tb_bayer_to_gray;

    localparam int RL = 4;
    localparam int PW = 12;

    logic          i_clk;
    logic          i_rst_n;
    logic [PW-1:0] i_data;
    logic          i_valid;
    logic          i_sof;
    logic [PW-1:0] o_data;
    logic          o_valid;
    logic          o_sof;

    int total = 0;
    int bad   = 0;

    logic [PW:0]   exp_q[$];
    logic [PW-1:0] last_exp;

    int m_row;
    int m_col;
    int prev_row [RL];
    int cur_row  [RL];

    bayer_to_gray #(
        .ROW_LENGTH (RL),
        .PIXEL_W    (PW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_sof   (o_sof)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Image model: neighbours are looked up by (row, col) in the current frame.
    function automatic logic [PW-1:0] model_px(input int p, input logic sof);
        int l, t, tl, s;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        l = (m_col > 0) ? cur_row[m_col-1] : p;
        if (m_row > 0) begin
            t  = prev_row[m_col];
            tl = (m_col > 0) ? prev_row[m_col-1] : prev_row[m_col];
        end else begin
            t  = p;
            tl = l;
        end
        s = (p + l + t + tl) / 4;
        cur_row[m_col] = p;
        m_col++;
        if (m_col == RL) begin
            m_col = 0;
            m_row++;
            prev_row = cur_row;
        end
        return PW'(s);
    endfunction

    // driver tasks
    task automatic drive_px(input logic [PW-1:0] pix, input logic sof,
                            input bit use_c, input logic [PW-1:0] cexp);
        logic [PW-1:0] m;
        m = model_px(int'(pix), sof);
        i_data  = pix;
        i_valid = 1'b1;
        i_sof   = sof;
        @(posedge i_clk);
        exp_q.push_back({sof, use_c ? cexp : m});
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = PW'($urandom_range(0, 4095));
    endtask

    task automatic idle_cyc(input int n);
        for (int k = 0; k < n; k++) begin
            i_sof = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            #1;
        end
        i_sof = 1'b0;
    endtask

    task automatic drive_const(input logic [PW-1:0] pix, input logic sof, input logic [PW-1:0] e);
        drive_px(pix, sof, 1'b1, e);
    endtask

    // scoreboard: one expected entry per accepted pixel, due on the next negedge
    always @(negedge i_clk) begin
        logic [PW:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("valid", 32'(o_valid), 32'd1);
            chk("data", 32'(o_data), 32'(e[PW-1:0]));
            chk("sof", 32'(o_sof), 32'(e[PW]));
            last_exp = e[PW-1:0];
        end else begin
            chk("idle_valid", 32'(o_valid), 32'd0);
            chk("idle_sof", 32'(o_sof), 32'd0);
            chk("hold", 32'(o_data), 32'(last_exp));
        end
    end

    initial begin
        i_rst_n  = 1'b0;
        i_data   = '0;
        i_valid  = 1'b0;
        i_sof    = 1'b0;
        last_exp = '0;
        m_row    = 0;
        m_col    = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sof", 32'(o_sof), 32'd0);
        i_rst_n = 1'b1;
        idle_cyc(2);

        // Row 0 and row 1, gap-free
        drive_const(100, 1'b1, 100);
        drive_const(200, 1'b0, 150);
        drive_const(300, 1'b0, 250);
        drive_const(400, 1'b0, 350);
        drive_const(500, 1'b0, 300);
        drive_const(600, 1'b0, 350);
        drive_const(700, 1'b0, 450);
        drive_const(800, 1'b0, 550);
        idle_cyc(2);

        // Same frame with idle gaps in row 1
        drive_const(100, 1'b1, 100);
        drive_const(200, 1'b0, 150);
        drive_const(300, 1'b0, 250);
        drive_const(400, 1'b0, 350);
        idle_cyc(1);
        drive_const(500, 1'b0, 300);
        idle_cyc(3);
        drive_const(600, 1'b0, 350);
        idle_cyc(2);
        drive_const(700, 1'b0, 450);
        idle_cyc(1);
        drive_const(800, 1'b0, 550);
        idle_cyc(2);

        // Saturation: two full rows at maximum
        for (int k = 0; k < 2 * RL; k++) drive_const(12'd4095, k == 0, 12'd4095);
        idle_cyc(1);

        // Truncation
        drive_const(1, 1'b1, 1);
        drive_const(2, 1'b0, 1);
        idle_cyc(1);

        // Mid-row sof on col 2 of row 1
        drive_const(100, 1'b1, 100);
        drive_const(200, 1'b0, 150);
        drive_const(300, 1'b0, 250);
        drive_const(400, 1'b0, 350);
        drive_const(500, 1'b0, 300);
        drive_const(600, 1'b0, 350);
        drive_const(40, 1'b1, 40);
        drive_const(80, 1'b0, 60);
        idle_cyc(2);

        // Reset pulse mid-row: outputs must clear without a clock edge
        drive_const(100, 1'b1, 100);
        drive_const(200, 1'b0, 150);
        #2;
        exp_q.delete();
        i_rst_n  = 1'b0;
        last_exp = '0;
        m_row    = 0;
        m_col    = 0;
        #1;
        chk("arst_data", 32'(o_data), 32'd0);
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_sof", 32'(o_sof), 32'd0);
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        drive_const(100, 1'b1, 100);
        drive_const(200, 1'b0, 150);
        drive_const(300, 1'b0, 250);
        drive_const(400, 1'b0, 350);
        idle_cyc(1);

        // Random frames with random gaps, checked by the image model
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 3 * RL; k++) begin
                logic [PW-1:0] px;
                px = ($urandom_range(0, 7) == 0) ? 12'd4095 : PW'($urandom_range(0, 4095));
                drive_px(px, k == 0, 1'b0, '0);
                if ($urandom_range(0, 3) == 0) idle_cyc($urandom_range(1, 3));
            end
        end

        idle_cyc(4);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bayer_to_gray.md
Name: bayer_to_gray

Overview:
- Streaming pre-processing stage directly upstream of the 3x3 Sobel convolution.
- Converts the 12-bit raw Bayer pixel stream from the camera capture path into a 12-bit grayscale stream at full input rate, one output per input pixel.
- Each output is the mean of the 2x2 neighbourhood ending at the current pixel, so every output mixes one R, one B and two G samples.
- Output handshake (o_data/o_valid) matches the convolution stage's i_data/i_valid directly.

Parameters:
- ROW_LENGTH, 1280, pixels per image row; sets line-buffer depth and column wrap point.
- PIXEL_W, 12, pixel width in bits for both input and output.

Ports:
- i_clk  input  1  system clock, all state on rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_data  input  PIXEL_W  raw Bayer pixel, unsigned.
- i_valid  input  1  i_data valid this cycle; one pixel accepted per valid cycle.
- i_sof  input  1  start of frame; qualified by i_valid; marks pixel (row 0, col 0).
- o_data  output  PIXEL_W  grayscale pixel, unsigned.
- o_valid  output  1  o_data valid this cycle.
- o_sof  output  1  o_data is the first pixel of a frame.

Behaviour:
- Clock and reset: one clock, i_clk; reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - o_data=0, o_valid=0, o_sof=0.
  - Column counter=0, first_row=1, previous-column registers=0.
  - Line buffer contents are don't-care; first_row masks them.
- Line buffer:
  - One delay line of depth ROW_LENGTH, width PIXEL_W.
  - Shifts only when i_valid=1, so its output is the pixel directly above the current one.
- Previous-column registers:
  - cur_prev captures i_data; top_prev captures the line-buffer output.
  - Both update only when i_valid=1.
- Neighbourhood selection per accepted pixel, p = current, l = left, t = top, tl = top-left:
  - col==0: l := p and tl := t (left edge replicated).
  - first_row=1: t := p and tl := l (top edge replicated; applied after the left-edge rule).
- Arithmetic:
  - sum = p + l + t + tl, computed unsigned in PIXEL_W+2 bits; no overflow possible.
  - o_data = sum >> 2, truncating (floor). Maximum input gives 4095.
- Latency and handshake:
  - Exactly 1 cycle: o_data, o_valid, o_sof are registered from the cycle i_valid=1.
  - o_valid <= i_valid; o_sof <= i_valid & i_sof.
  - When i_valid=0: o_valid=0, o_data holds its last value, and no internal state changes.
  - No backpressure; downstream must accept every o_valid cycle.
- Counters:
  - Column counter increments per accepted pixel and wraps ROW_LENGTH-1 -> 0.
  - On the wrap, first_row clears.
- i_sof behaviour:
  - When i_valid & i_sof, the current pixel is treated as col 0, first_row=1, regardless of counter state.
  - Counters then continue from col 1. This also covers a mid-row sof or a short previous frame.
- Reset mid-frame: all state returns to reset values at once; output is garbage-free until the next sof.
- i_sof without i_valid is ignored.

Decomposition:
- Shared package: PIXEL_W, the default ROW_LENGTH, and a pixel_t typedef (logic [PIXEL_W-1:0]). The convolution stage uses the same package.
- Sub-module: reuse the existing shift_register (WIDTH=PIXEL_W, DEPTH=ROW_LENGTH, i_shift=i_valid) as the line buffer.
- Counters, edge muxing and the adder tree live in this module.

Test Plan:
- Row 0 (ROW_LENGTH=4): sof+100, then 200, 300, 400 -> o_data 100, 150, 250, 350, each 1 cycle after input; o_sof=1 only with 100.
- Row 1: 500, 600, 700, 800 -> 300, 350, 450, 550 (e.g. (600+500+200+100)/4=350).
- Saturation: all pixels 4095 for 2 rows -> every output 4095, no wrap. Truncation: row 0 inputs 1, 2 -> outputs 1, 1.
- i_valid gaps: row 1 input with idle cycles between pixels -> same values as the gap-free case; o_valid low during gaps; o_data holds.
- Mid-row sof: assert sof on col 2 of row 1 with value 40 -> output 40; the next pixel is treated as col 1 of a first row.
- Reset pulse mid-row: o_valid/o_data/o_sof go to 0 asynchronously. A new frame after release reproduces the Row 0 values exactly.
